// File: rtl/asg_memory_reader.sv
// ASG sequence memory read side: streams n terms from addresses 0..n-1.
// Optional macro ASG_READ_VERIFY_EN adds an arithmetic-progression compare.
module asg_memory_reader #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [31:0]       n,
   output logic              mem_read_enable,
   output logic [ADDR_W-1:0] mem_address,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic              busy,
   output logic              sequence_read_complete
`ifdef ASG_READ_VERIFY_EN
   ,
   input  logic [DATA_W-1:0] a1,
   input  logic [DATA_W-1:0] d,
   output logic              mismatch,
   output logic [15:0]       error_count
`endif
);

   localparam int CW = ADDR_W + 1;
   localparam logic [CW-1:0] MAX_TERMS = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state, state_nx;

   logic [CW-1:0]     n_lat;
   logic [CW-1:0]     n_clamp;
   logic [CW-1:0]     issued;
   logic [CW-1:0]     popped;
   logic              inflight;
   logic [DATA_W-1:0] fifo_mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        fifo_count;
   logic [1:0]        occ;
   logic              push;
   logic              pop;
   logic              issue;
   logic              start_acc;

   assign n_clamp   = (n > 32'(MAX_TERMS)) ? MAX_TERMS : n[CW-1:0];
   assign push      = inflight;
   assign out_valid = (fifo_count != 2'd0);
   assign out_data  = fifo_mem[rd_ptr];
   assign pop       = out_valid & out_ready;
   assign out_last  = out_valid & (popped == n_lat - 1'b1);

   // Occupancy as seen after this edge; counting the pop keeps full rate.
   assign occ = fifo_count + {1'b0, inflight} - {1'b0, pop};

   always_comb begin
      state_nx               = state;
      issue                  = 1'b0;
      start_acc              = 1'b0;
      mem_read_enable        = 1'b0;
      mem_address            = '0;
      busy                   = 1'b0;
      sequence_read_complete = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               state_nx  = (n_clamp == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            busy = 1'b1;
            if ((issued != n_lat) && !occ[1]) begin
               issue           = 1'b1;
               mem_read_enable = 1'b1;
               mem_address     = issued[ADDR_W-1:0];
               if (issued + 1'b1 == n_lat)
                  state_nx = S_DRAIN;
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (pop && (popped + 1'b1 == n_lat))
               state_nx = S_DONE;
         end
         S_DONE: begin
            sequence_read_complete = 1'b1;
            if (!start)
               state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         n_lat       <= '0;
         issued      <= '0;
         popped      <= '0;
         inflight    <= 1'b0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_count  <= 2'd0;
      end else begin
         state    <= state_nx;
         inflight <= issue;
         if (start_acc) begin
            n_lat  <= n_clamp;
            issued <= '0;
            popped <= '0;
         end else begin
            if (issue)
               issued <= issued + 1'b1;
            if (pop)
               popped <= popped + 1'b1;
         end
         if (push) begin
            fifo_mem[wr_ptr] <= mem_read_data;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         unique case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

`ifdef ASG_READ_VERIFY_EN
   logic [DATA_W-1:0] expected;
   logic [DATA_W-1:0] d_lat;
   logic              bad;

   assign bad = (out_data != expected);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         expected    <= '0;
         d_lat       <= '0;
         mismatch    <= 1'b0;
         error_count <= 16'd0;
      end else begin
         mismatch <= 1'b0;
         if (start_acc) begin
            expected    <= a1;
            d_lat       <= d;
            error_count <= 16'd0;
         end else if (pop) begin
            mismatch <= bad;
            expected <= expected + d_lat;
            if (bad && (error_count != 16'hFFFF))
               error_count <= error_count + 16'd1;
         end
      end
   end
`endif

endmodule
